// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer.
//   state_e   : sequencer state encoding (also exported on the debug port)
//   opclass_e : instruction class latched in DECODE
//   OP_*      : major opcode values recognised by the decoder
//   ALU_*     : aluOP encodings driven to the ALU control
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5
  } opclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_opclass.sv
// Combinational opcode classifier.
//   opcode   : I[6:0] from the instruction register
//   op_class : decoded instruction class (CLS_NONE when unsupported)
//   op_valid : 1 when the opcode is one the sequencer can execute
module ctrl_opclass
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   op_class,
  output logic       op_valid
);

  always_comb begin
    op_class = CLS_NONE;
    op_valid = 1'b1;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_IMM:    op_class = CLS_IMM;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      default:   op_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RISC-V datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath controls.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   I                 : instruction register, only I[6:0] is decoded
//   halt              : 1 = do not start a new instruction
//   imem_ack/dmem_ack : memory handshake completions
//   imem_req, ir_write, pc_write       : fetch control
//   alusrc, memToReg, regWrite, memRead, memWrite, branch, aluOP : datapath
//   retire / illegal  : single-cycle completion / unsupported-opcode pulses
//   state             : current state for debug
//
// Optional build macro MULTICYCLE_PERF_CNT_EN adds cycle_cnt (cycles spent
// outside IDLE) and instret_cnt (retired instructions), CNT_W bits, wrapping.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      I,
  input  logic             halt,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alusrc,
  output logic             memToReg,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             branch,
  output logic [1:0]       aluOP,
`ifdef MULTICYCLE_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("multicycle_ctrl: CNT_W must be at least 1");
  end

  state_e   state_q, state_d;
  opclass_e class_q, class_d;
  opclass_e dec_class;
  logic     dec_valid;

  // Only the major opcode matters here; the rest of I feeds the datapath.
  logic unused_i_hi;
  assign unused_i_hi = ^I[31:7];

  ctrl_opclass u_opclass (
    .opcode   (I[6:0]),
    .op_class (dec_class),
    .op_valid (dec_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      class_q <= CLS_NONE;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    alusrc   = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    branch   = 1'b0;
    aluOP    = ALU_ADD;
    retire   = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!halt) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        // IR and PC update on the same edge that accepts the fetch data.
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        class_d = dec_class;
        if (dec_valid) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = halt ? ST_IDLE : ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (class_q)
          CLS_R: begin
            aluOP   = ALU_FUNCT;
            state_d = ST_WB;
          end
          CLS_IMM: begin
            aluOP   = ALU_FUNCT;
            alusrc  = 1'b1;
            state_d = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            aluOP   = ALU_ADD;
            alusrc  = 1'b1;
            state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            // Branch completes here; the datapath qualifies it with zero.
            aluOP   = ALU_SUB;
            branch  = 1'b1;
            retire  = 1'b1;
            state_d = halt ? ST_IDLE : ST_FETCH;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      ST_MEM: begin
        // Address stays on the ALU output for the whole access.
        aluOP  = ALU_ADD;
        alusrc = 1'b1;
        if (class_q == CLS_LOAD) begin
          memRead = 1'b1;
          if (dmem_ack) state_d = ST_WB;
        end else if (class_q == CLS_STORE) begin
          memWrite = 1'b1;
          if (dmem_ack) begin
            retire  = 1'b1;
            state_d = halt ? ST_IDLE : ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WB: begin
        regWrite = 1'b1;
        memToReg = (class_q == CLS_LOAD);
        retire   = 1'b1;
        state_d  = halt ? ST_IDLE : ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != ST_IDLE) cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
    if (retire)             instret_cnt_d = instret_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. A generator expands each instruction
// into per-cycle stimulus and expected-output entries from the phase rules of
// the sequencer; a driver replays the stimulus and a monitor pops and checks.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       alusrc;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] aluop;
    logic       retire;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        halt;
    logic        ia;
    logic        da;
  } stim_t;

  logic        clk;
  logic        rst;
  logic [31:0] I;
  logic        halt, imem_ack, dmem_ack;
  logic        imem_req, ir_write, pc_write, alusrc, memToReg, regWrite;
  logic        memRead, memWrite, branch, retire, illegal;
  logic [1:0]  aluOP;
  logic [2:0]  state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .I           (I),
    .halt        (halt),
    .imem_ack    (imem_ack),
    .dmem_ack    (dmem_ack),
    .imem_req    (imem_req),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .alusrc      (alusrc),
    .memToReg    (memToReg),
    .regWrite    (regWrite),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .branch      (branch),
    .aluOP       (aluOP),
`ifdef MULTICYCLE_PERF_CNT_EN
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
`endif
    .retire      (retire),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic exp_t actual();
    exp_t a;
    a.st = state; a.imem_req = imem_req; a.ir_write = ir_write;
    a.pc_write = pc_write; a.alusrc = alusrc; a.mem_to_reg = memToReg;
    a.reg_write = regWrite; a.mem_read = memRead; a.mem_write = memWrite;
    a.branch = branch; a.aluop = aluOP; a.retire = retire; a.illegal = illegal;
    return a;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic stim_t mks(input logic [31:0] ins, input logic h,
                                input logic ia, input logic da);
    stim_t s;
    s.instr = ins; s.halt = h; s.ia = ia; s.da = da;
    return s;
  endfunction

  function automatic exp_t z(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic void push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  // After a completing cycle with halt=1: sit in IDLE, then restart.
  function automatic void gen_idle(input logic hlt, input int idles);
    if (hlt) begin
      for (int k = 0; k < idles; k++) push(mks($urandom, 1'b1, rb(), rb()), z(3'd0));
      push(mks($urandom, 1'b0, rb(), rb()), z(3'd0));
    end
  endfunction

  // Expected behaviour of one instruction from FETCH entry to completion.
  function automatic void gen_instr(input logic [31:0] ins, input int iw,
                                    input int dw, input logic hlt, input int idles);
    logic [6:0] op;
    bit   is_r, is_i, is_ld, is_st, is_br;
    exp_t e;
    op    = ins[6:0];
    is_r  = (op == 7'b0110011);
    is_i  = (op == 7'b0010011);
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    is_br = (op == 7'b1100011);

    for (int k = 0; k < iw; k++) begin
      e = z(3'd1); e.imem_req = 1'b1;
      push(mks(ins, rb(), 1'b0, rb()), e);
    end
    e = z(3'd1); e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(mks(ins, rb(), 1'b1, rb()), e);

    e = z(3'd2);
    if (!(is_r || is_i || is_ld || is_st || is_br)) begin
      e.illegal = 1'b1;
      push(mks(ins, hlt, rb(), rb()), e);
      gen_idle(hlt, idles);
      return;
    end
    push(mks(ins, rb(), rb(), rb()), e);

    e = z(3'd3);
    e.alusrc = is_i || is_ld || is_st;
    e.aluop  = (is_r || is_i) ? 2'b10 : (is_br ? 2'b01 : 2'b00);
    if (is_br) begin
      e.branch = 1'b1; e.retire = 1'b1;
      push(mks(ins, hlt, rb(), rb()), e);
      gen_idle(hlt, idles);
      return;
    end
    push(mks(ins, rb(), rb(), rb()), e);

    if (is_ld || is_st) begin
      e = z(3'd4); e.alusrc = 1'b1; e.mem_read = is_ld; e.mem_write = is_st;
      for (int k = 0; k < dw; k++) push(mks(ins, rb(), rb(), 1'b0), e);
      e.retire = is_st;
      push(mks(ins, is_st ? hlt : rb(), rb(), 1'b1), e);
      if (is_st) begin
        gen_idle(hlt, idles);
        return;
      end
    end

    e = z(3'd5); e.reg_write = 1'b1; e.mem_to_reg = is_ld; e.retire = 1'b1;
    push(mks(ins, hlt, rb(), rb()), e);
    gen_idle(hlt, idles);
  endfunction

  task automatic drive();
    stim_t s;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      I = s.instr; halt = s.halt; imem_ack = s.ia; dmem_ack = s.da;
    end
  endtask

  task automatic monitor();
    exp_t        e, a;
    int          cyc = 0;
    logic [31:0] exp_cyc = '0;
    logic [31:0] exp_ret = '0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle %0d ctrl_outputs: actual=%h required=%h (state %0d vs %0d)",
                 cyc, a, e, a.st, e.st);
      end
`ifdef MULTICYCLE_PERF_CNT_EN
      n_checks++;
      if (cycle_cnt !== exp_cyc || instret_cnt !== exp_ret) begin
        n_fail++;
        $display("FAIL cycle %0d perf_counters: actual=%0d/%0d required=%0d/%0d",
                 cyc, cycle_cnt, instret_cnt, exp_cyc, exp_ret);
      end
`endif
      if (e.st != 3'd0) exp_cyc = exp_cyc + 32'd1;
      if (e.retire)     exp_ret = exp_ret + 32'd1;
      cyc++;
    end
  endtask

  initial begin
    logic [6:0]  ops [5];
    logic [6:0]  op;
    logic [31:0] r;
    int          k;
    bit          found;
    exp_t        a;

    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011;

    // Reset held with active-looking inputs: everything must stay quiet.
    rst = 1'b0; halt = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; I = 32'h00208033;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a = actual();
      n_checks++;
      if (a !== '0) begin
        n_fail++;
        $display("FAIL reset_state: actual=%h required=0", a);
      end
    end
    halt = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Program: the directed cases first, then a randomised stream.
    push(mks($urandom, 1'b0, 1'b0, 1'b0), z(3'd0));
    gen_instr(32'h00208033, 0, 0, 1'b0, 0);
    gen_instr(32'h00012083, 0, 3, 1'b0, 0);
    gen_instr(32'h00112023, 0, 0, 1'b0, 0);
    gen_instr(32'h00000063, 0, 0, 1'b0, 0);
    gen_instr(32'h0000007F, 0, 0, 1'b0, 0);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 5);
      if (k < 5) op = ops[k];
      else begin
        do op = 7'($urandom); while (op == ops[0] || op == ops[1] || op == ops[2] ||
                                     op == ops[3] || op == ops[4]);
      end
      r = $urandom;
      gen_instr({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end
    gen_instr(32'h00208033, 0, 0, 1'b1, 1);

    fork
      drive();
      monitor();
    join

    // Load stalled in MEM, then reset pulled mid-cycle.
    @(negedge clk);
    I = 32'h00012083; halt = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (state == 3'd4) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL mem_stall_reach: actual state=%0d required=4", state);
    end else begin
      n_checks++;
      if (memRead !== 1'b1 || memWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL mem_stall_ctrl: actual rd/wr=%b%b required=10", memRead, memWrite);
      end
      #2;
      rst = 1'b0;
      #1;
      a = actual();
      n_checks++;
      if (a !== '0) begin
        n_fail++;
        $display("FAIL async_reset_outputs: actual=%h required=0", a);
      end
`ifdef MULTICYCLE_PERF_CNT_EN
      n_checks++;
      if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL async_reset_counters: actual=%0d/%0d required=0/0",
                 cycle_cnt, instret_cnt);
      end
`endif
      dmem_ack = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        a = actual();
        n_checks++;
        if (a !== '0) begin
          n_fail++;
          $display("FAIL reset_hold_quiet: actual=%h required=0", a);
        end
      end
      rst = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
